// File: rtl/qs_enq_nbnk.sv
// Multi-bank sorter enqueue stage: frames from a vld/rdy stream are written
// into a ring of N-entry banks, and filled banks are offered to the sort stage
// in strict ring order. Over-length frames are truncated and flagged.
module qs_enq_nbnk #(
  parameter int W     = 32,
  parameter int N     = 16,
  parameter int BANKS = 2,
  localparam int AW   = $clog2(N),
  localparam int BW   = $clog2(BANKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [W-1:0]  in_dat,
  output logic          in_rdy,
  output logic          wr_en_r,
  output logic [BW-1:0] wr_bnk_r,
  output logic [AW-1:0] wr_addr_r,
  output logic [W-1:0]  wr_dat_r,
  output logic          bnk_rdy_vld_r,
  output logic [BW-1:0] bnk_rdy_idx_r,
  output logic [AW:0]   bnk_rdy_len_r,
  output logic          bnk_rdy_err_r,
  input  logic          bnk_rdy_ack,
  input  logic          bnk_done,
  input  logic [BW-1:0] bnk_done_idx
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} fsm_t;
  typedef enum logic [1:0] {B_FREE, B_FILL, B_READY, B_OWNED} bst_t;

  localparam logic [AW:0] NL = (AW+1)'(N);

  fsm_t          state, state_nx;
  bst_t          bst [BANKS];
  logic [AW:0]   blen [BANKS];
  logic          berr [BANKS];
  logic [BW-1:0] fill_ptr, offer_ptr;
  logic [AW:0]   cnt, cnt_nx;
  logic          ferr, ferr_nx;
  logic          acc, take, wr, alloc, close, cerr;
  logic [AW-1:0] waddr;
  logic [AW:0]   clen;

  // Outside IDLE everything is accepted; in IDLE only a SOP needs a free bank,
  // so stray non-SOP beats always drain.
  assign in_rdy = (state != S_IDLE) | ~in_sop | (bst[fill_ptr] == B_FREE);
  assign acc    = in_vld & in_rdy;
  assign take   = bnk_rdy_vld_r & bnk_rdy_ack;

  // Frame FSM next state and per-beat write/close decisions
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ferr_nx  = ferr;
    wr       = 1'b0;
    waddr    = '0;
    alloc    = 1'b0;
    close    = 1'b0;
    clen     = '0;
    cerr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc && in_sop) begin
          wr      = 1'b1;
          alloc   = 1'b1;
          cnt_nx  = (AW+1)'(1);
          ferr_nx = 1'b0;
          if (in_eop) begin
            close = 1'b1;
            clen  = (AW+1)'(1);
          end else begin
            state_nx = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (acc) begin
          wr    = 1'b1;
          waddr = cnt[AW-1:0];
          if (in_sop) ferr_nx = 1'b1;
          if (in_eop) begin
            close    = 1'b1;
            clen     = cnt + 1'b1;
            cerr     = ferr | in_sop;
            state_nx = S_IDLE;
          end else if (cnt == NL - 1'b1) begin
            // Bank is full without EOP: close it now and drop the tail.
            close    = 1'b1;
            clen     = NL;
            cerr     = 1'b1;
            state_nx = S_DROP;
          end else begin
            cnt_nx = (cnt == NL) ? cnt : cnt + 1'b1;
          end
        end
      end
      S_DROP: begin
        if (acc && in_eop) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Frame FSM, beat counter, error latch and ring pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ferr      <= 1'b0;
      fill_ptr  <= '0;
      offer_ptr <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ferr  <= ferr_nx;
      if (close) fill_ptr  <= (fill_ptr == BW'(BANKS-1)) ? '0 : fill_ptr + 1'b1;
      if (take)  offer_ptr <= (offer_ptr == BW'(BANKS-1)) ? '0 : offer_ptr + 1'b1;
    end
  end

  // Per-bank ownership; close, ack and done always hit banks in distinct states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < BANKS; b++) begin
        bst[b]  <= B_FREE;
        blen[b] <= '0;
        berr[b] <= 1'b0;
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (alloc && fill_ptr == BW'(b)) bst[b] <= B_FILL;
        if (close && fill_ptr == BW'(b)) begin
          bst[b]  <= B_READY;
          blen[b] <= clen;
          berr[b] <= cerr;
        end
        if (take && offer_ptr == BW'(b)) bst[b] <= B_OWNED;
        if (bnk_done && bnk_done_idx == BW'(b) && bst[b] == B_OWNED) bst[b] <= B_FREE;
      end
    end
  end

  // Registered bank write port, one cycle behind the accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r   <= 1'b0;
      wr_bnk_r  <= '0;
      wr_addr_r <= '0;
      wr_dat_r  <= '0;
    end else begin
      wr_en_r <= wr;
      if (wr) begin
        wr_bnk_r  <= fill_ptr;
        wr_addr_r <= waddr;
        wr_dat_r  <= in_dat;
      end
    end
  end

  // Registered offer; drops for one cycle after each ack so the pointer settles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bnk_rdy_vld_r <= 1'b0;
      bnk_rdy_idx_r <= '0;
      bnk_rdy_len_r <= '0;
      bnk_rdy_err_r <= 1'b0;
    end else begin
      bnk_rdy_vld_r <= ~take & (bst[offer_ptr] == B_READY);
      bnk_rdy_idx_r <= offer_ptr;
      bnk_rdy_len_r <= blen[offer_ptr];
      bnk_rdy_err_r <= berr[offer_ptr];
    end
  end

endmodule

// File: tb/tb_qs_enq_nbnk.sv
// Bench for qs_enq_nbnk: directed scenarios followed by random traffic, all
// checked every cycle against a frame-level reference model.
module tb_qs_enq_nbnk;
  localparam int W = 32, N = 16, BANKS = 2, AW = 4, BW = 1;

  logic          clk = 1'b0, rst = 1'b0;
  logic          in_vld = 0, in_sop = 0, in_eop = 0;
  logic [W-1:0]  in_dat = '0;
  logic          in_rdy;
  logic          wr_en_r;
  logic [BW-1:0] wr_bnk_r;
  logic [AW-1:0] wr_addr_r;
  logic [W-1:0]  wr_dat_r;
  logic          bnk_rdy_vld_r;
  logic [BW-1:0] bnk_rdy_idx_r;
  logic [AW:0]   bnk_rdy_len_r;
  logic          bnk_rdy_err_r;
  logic          bnk_rdy_ack = 0, bnk_done = 0;
  logic [BW-1:0] bnk_done_idx = '0;

  always #5 clk = ~clk;

  qs_enq_nbnk #(.W(W), .N(N), .BANKS(BANKS)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_dat(in_dat), .in_rdy(in_rdy),
    .wr_en_r(wr_en_r), .wr_bnk_r(wr_bnk_r), .wr_addr_r(wr_addr_r), .wr_dat_r(wr_dat_r),
    .bnk_rdy_vld_r(bnk_rdy_vld_r), .bnk_rdy_idx_r(bnk_rdy_idx_r),
    .bnk_rdy_len_r(bnk_rdy_len_r), .bnk_rdy_err_r(bnk_rdy_err_r),
    .bnk_rdy_ack(bnk_rdy_ack), .bnk_done(bnk_done), .bnk_done_idx(bnk_done_idx)
  );

  int ncmp = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame parser, bank occupancy, expected writes and offers
  typedef struct {int bnk; int len; int err; int rdy;} offer_t;
  offer_t oq[$];
  int mode, cnt, ferr, fill, cy, last_ack;
  bit free_b[BANKS], owned[BANKS];
  bit pw; int pw_bnk, pw_addr; logic [W-1:0] pw_dat;

  task automatic model_reset();
    mode = 0; cnt = 0; ferr = 0; fill = 0; last_ack = -10; pw = 0;
    oq.delete();
    for (int b = 0; b < BANKS; b++) begin free_b[b] = 1; owned[b] = 0; end
  endtask

  task automatic mwrite(input int b, input int a, input logic [W-1:0] d);
    pw = 1; pw_bnk = b; pw_addr = a; pw_dat = d;
  endtask

  task automatic mclose(input int len, input int err);
    oq.push_back('{fill, len, err, cy + 2});
    fill = (fill + 1) % BANKS;
  endtask

  // One clock cycle: check outputs, drive inputs, check in_rdy, advance model.
  task automatic cyc(input bit v, input bit s, input bit e, input logic [W-1:0] d,
                     input bit a, input bit dn, input int di, output bit acc);
    bit ev, er;
    int dsel;
    chk("wr_en", wr_en_r, pw);
    if (pw) begin
      chk("wr_bnk", wr_bnk_r, pw_bnk);
      chk("wr_addr", wr_addr_r, pw_addr);
      chk("wr_dat", wr_dat_r, pw_dat);
    end
    ev = oq.size() > 0 && cy >= oq[0].rdy && cy >= last_ack + 2;
    chk("rdy_vld", bnk_rdy_vld_r, ev);
    if (ev) begin
      chk("rdy_idx", bnk_rdy_idx_r, oq[0].bnk);
      chk("rdy_len", bnk_rdy_len_r, oq[0].len);
      chk("rdy_err", bnk_rdy_err_r, oq[0].err);
    end
    dsel = di;
    if (dsel < 0) begin
      dsel = 0;
      for (int b = BANKS - 1; b >= 0; b--) if (owned[b]) dsel = b;
    end
    in_vld = v; in_sop = s; in_eop = e; in_dat = d;
    bnk_rdy_ack = a; bnk_done = dn; bnk_done_idx = BW'(dsel);
    #1;
    er = (mode != 0) || !s || free_b[fill];
    chk("in_rdy", in_rdy, er);
    acc = v && er;
    pw = 0;
    if (acc) begin
      case (mode)
        0: if (s) begin
             free_b[fill] = 0;
             mwrite(fill, 0, d);
             if (e) mclose(1, 0);
             else begin mode = 1; cnt = 1; ferr = 0; end
           end
        1: begin
             mwrite(fill, cnt, d);
             if (e) begin mclose(cnt + 1, ferr | s); mode = 0; end
             else if (cnt == N - 1) begin mclose(N, 1); mode = 2; end
             else begin cnt++; ferr = ferr | s; end
           end
        default: if (e) mode = 0;
      endcase
    end
    // done acts on the pre-ack state, so it is applied before the ack
    if (dn && owned[dsel]) begin owned[dsel] = 0; free_b[dsel] = 1; end
    if (a && ev) begin owned[oq[0].bnk] = 1; void'(oq.pop_front()); last_ack = cy; end
    @(posedge clk); #1;
    cy++;
  endtask

  task automatic idle(input int n, input bit a, input bit dn);
    bit acc;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, a, dn, -1, acc);
  endtask

  task automatic send_frame(input int len, input logic [W-1:0] base, input bit a, input bit dn);
    bit acc;
    for (int i = 0; i < len; i++) begin
      int tries = 0;
      do begin
        cyc(1, i == 0, i == len - 1, base + W'(i), a, dn, -1, acc);
        tries++;
      end while (!acc && tries < 100);
      if (!acc) begin chk("stall_in_rdy", in_rdy, 1'b1); return; end
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wr_en", wr_en_r, 0);
    chk("rst_wr_bnk", wr_bnk_r, 0);
    chk("rst_wr_addr", wr_addr_r, 0);
    chk("rst_wr_dat", wr_dat_r, 0);
    chk("rst_vld", bnk_rdy_vld_r, 0);
    chk("rst_idx", bnk_rdy_idx_r, 0);
    chk("rst_len", bnk_rdy_len_r, 0);
    chk("rst_err", bnk_rdy_err_r, 0);
  endtask

  initial begin
    bit acc;
    int flen, pos;
    bit garb;
    cy = 0;
    model_reset();
    #1;
    chk_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // 4-beat frame into bank 0, offered two cycles after EOP, then acked
    send_frame(4, 32'hA, 0, 0);
    idle(3, 0, 0);
    idle(2, 1, 0);
    idle(1, 0, 1);
    // single-beat frame, data 0x55, into bank 1
    cyc(1, 1, 1, 32'h55, 0, 0, -1, acc);
    idle(4, 1, 1);
    // 19 beats: 16 written, 3 dropped, len=16 err=1; next frame to bank 1
    send_frame(19, 32'h100, 0, 0);
    send_frame(2, 32'h200, 0, 0);
    idle(10, 1, 1);
    // both banks filled, no ack/done: third SOP blocked until ack and done
    send_frame(2, 32'h300, 0, 0);
    send_frame(3, 32'h400, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h500, 0, 0, -1, acc);
    cyc(1, 1, 0, 32'h500, 1, 0, -1, acc);
    cyc(1, 1, 0, 32'h500, 0, 1, 0, acc);
    send_frame(3, 32'h500, 0, 0);
    idle(12, 1, 1);
    // stray non-SOP beats in IDLE drain without writes
    for (int i = 0; i < 4; i++) cyc(1, 0, i[0], 32'h600 + W'(i), 0, 0, -1, acc);
    idle(2, 0, 0);
    // reset mid-frame after five beats
    for (int i = 0; i < 5; i++) cyc(1, i == 0, 0, 32'h700 + W'(i), 0, 0, -1, acc);
    rst = 1'b0;
    #2;
    chk_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(0, 0, 0, '0, 0, 1, 1, acc);
    send_frame(2, 32'h800, 0, 1);
    idle(6, 1, 1);

    // random traffic
    flen = 0; pos = 0; garb = 0;
    for (int i = 0; i < 3000; i++) begin
      bit s, e, a, dn;
      int di;
      if (pos == 0 && flen == 0) begin
        garb = ($urandom % 10) == 0;
        flen = garb ? 1 : $urandom_range(1, 20);
      end
      s = garb ? 1'b0 : (pos == 0 || ($urandom % 40) == 0);
      e = garb ? 1'($urandom % 2) : (pos == flen - 1);
      a = ($urandom % 3) == 0;
      dn = ($urandom % 4) == 0;
      di = (($urandom % 8) == 0) ? int'($urandom % BANKS) : -1;
      cyc(($urandom % 4) != 0, s, e, $urandom, a, dn, di, acc);
      if (acc) begin
        pos++;
        if (pos >= flen) begin pos = 0; flen = 0; end
      end
    end
    // finish any open frame, then drain every offer
    if (flen != 0) begin
      bit done_f = 0;
      for (int t = 0; t < 200 && !done_f; t++) begin
        cyc(1, 0, 1, '0, 1, 1, -1, acc);
        done_f = acc;
      end
    end
    for (int t = 0; t < 300 && oq.size() > 0; t++) idle(1, 1, 1);
    chk("drain_offers_left", 64'(oq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/qs_enq_nbnk.md
Name: qs_enq_nbnk

Overview:
- Parametrised, multi-bank successor to the sorter enqueue stage.
- Accepts unsorted frames on a vld/rdy stream and writes each frame into the next bank of a BANKS-deep ring of N-entry banks.
- Tracks per-bank ownership (FREE/FILL/READY/OWNED) and hands completed banks to the sort stage in strict ring order.
- Adds over-length truncation with error flagging and bank recycling; the single-bank enqueue stage has neither.

Parameters:
W, 32, data word width.
N, 16, entries per bank; power of two, >=2.
BANKS, 2, number of banks in the ring; >=2.
AW, $clog2(N), entry address width (derived, do not override).
BW, $clog2(BANKS), bank index width (derived, do not override).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
in_vld  in  1  input beat valid.
in_sop  in  1  first beat of frame.
in_eop  in  1  last beat of frame.
in_dat  in  W  input data.
in_rdy  out  1  input ready; combinational from registered state.
wr_en_r  out  1  bank write strobe.
wr_bnk_r  out  BW  bank written.
wr_addr_r  out  AW  entry written.
wr_dat_r  out  W  write data.
bnk_rdy_vld_r  out  1  a filled bank is offered to the sort stage.
bnk_rdy_idx_r  out  BW  offered bank index.
bnk_rdy_len_r  out  AW+1  entries held, 1..N.
bnk_rdy_err_r  out  1  frame was truncated or malformed.
bnk_rdy_ack  in  1  sort stage takes ownership of the offered bank.
bnk_done  in  1  one-cycle pulse: a bank is released.
bnk_done_idx  in  BW  bank released.

Behaviour:
- Reset (rst=0, async): all banks FREE; fill and offer pointers = 0; FSM IDLE; all *_r outputs 0.
- Per-bank state: FREE -> FILL (allocated on SOP) -> READY (EOP written or truncated) -> OWNED (ack) -> FREE (bnk_done with matching idx).
- bnk_done naming a bank that is not OWNED is ignored.
- Allocation: strictly in ring order. Fill pointer advances by 1 mod BANKS on each frame close. A frame may only start if bank[fill_ptr] is FREE.
- FSM IDLE:
  - in_rdy=1 if bank[fill_ptr] FREE, else 0.
  - Accepted beat with sop=1: writes entry 0, bank -> FILL, cnt=1.
  - If eop=1 on the same beat, close immediately with len=1 and stay IDLE; otherwise go to FILL.
  - Accepted beat with sop=0: discarded, no write. in_rdy stays 1 in this case so garbage drains regardless of bank state.
- FSM FILL: in_rdy=1.
  - Each accepted beat writes entry cnt, then cnt++.
  - sop=1 mid-frame: data is written, err flag latched, frame continues.
  - eop=1: close with len=cnt+1, go to IDLE.
  - If the accepted beat is entry N-1 without eop: close with len=N, err=1, go to DROP.
- FSM DROP: in_rdy=1. Beats are discarded with no writes; on eop go to IDLE. The bank was already closed on entry.
- Write port latency: a beat accepted in cycle t drives wr_en_r/wr_bnk_r/wr_addr_r/wr_dat_r in cycle t+1. wr_en_r=0 when nothing is written.
- Close: the bank goes READY in cycle t+1, where t is the closing beat; len and err are stored per bank.
- Offer:
  - bnk_rdy_vld_r=1 while bank[offer_ptr] is READY, registered. Earliest assertion is t+2, so the last write has landed before the offer.
  - idx, len and err are held stable while vld=1 and ack=0.
  - On ack with vld=1: bank -> OWNED, offer_ptr++ mod BANKS, vld drops the next cycle. The next READY bank can be offered one cycle later.
  - ack with vld=0 is ignored.
- Simultaneous events in one cycle:
  - Close, ack and done may all occur together.
  - done for bank k and a new SOP allocation of bank k in the same cycle: the allocation uses the pre-update state, so the SOP is not accepted (in_rdy=0). It is accepted the next cycle.
- Width: cnt is AW+1 bits and saturates at N.

Test Plan:
- N=16, BANKS=2: frame of 4 beats, data 0xA..0xD, sop on the first, eop on the last.
  -> wr_addr 0..3 into bank 0.
  -> bnk_rdy_vld_r at cycle 2 after eop, with idx=0, len=4, err=0.
  -> ack -> vld drops the next cycle.
- Single beat with sop=eop=1, data 0x55.
  -> one write to addr 0.
  -> offer len=1, err=0.
- 19-beat frame, N=16.
  -> 16 writes, then 3 beats discarded.
  -> offer len=16, err=1.
  -> the next frame goes to bank 1.
- Fill both banks, withhold ack and done, present a third SOP.
  -> in_rdy=0 until bank 0 has been acked and bnk_done idx=0 is pulsed.
  -> the frame is then written to bank 0.
- Beats with sop=0 in IDLE.
  -> accepted (in_rdy=1) with no writes and no offer.
- Assert rst low mid-frame (after beat 5).
  -> all outputs 0 immediately; banks FREE.
  -> the next SOP writes bank 0, addr 0.
  -> a spurious bnk_done idx=1 is ignored.
